fb_readback_sequencer: RTL and testbench
========================================

FB_READBACK_SEQUENCER -- requirements
Module: fb_readback_sequencer

Interface
REQ-001 Parameter X_STEP, default 10, column stride between chunk reads.
REQ-002 Parameter Y_STEP, default 10, row stride between chunk reads.
REQ-003 Parameter X_LIMIT, default 640, exclusive upper bound of fb_x.
REQ-004 Parameter Y_LIMIT, default 480, exclusive upper bound of fb_y.
REQ-005 Parameter TIMEOUT, default 1023, max cycles waiting for fb_data_ready.
REQ-006 clk  in  1  clock; all logic on rising edge.
REQ-007 reset  in  1  reset, asynchronous, active-high.
REQ-008 start  in  1  single-cycle request to begin a full framebuffer readback.
REQ-009 fb_x  out  10  framebuffer column address of current chunk.
REQ-010 fb_y  out  10  framebuffer row address of current chunk.
REQ-011 fb_read  out  1  read request to framebuffer.
REQ-012 fb_chunk  in  100  chunk data returned by framebuffer.
REQ-013 fb_data_ready  in  1  framebuffer chunk valid, one-cycle pulse.
REQ-014 tx_data  out  8  byte to UART transmitter.
REQ-015 tx_valid  out  1  tx_data valid.
REQ-016 tx_ready  in  1  transmitter accepts byte.
REQ-017 busy  out  1  high in any state other than IDLE/DONE.
REQ-018 done  out  1  level, high after full readback until next accepted start.
REQ-019 timeout_err  out  1  sticky, framebuffer failed to answer within TIMEOUT.

Function
REQ-020 FSM states IDLE, READ, SEND, ADVANCE, DONE.
REQ-021 IDLE/DONE: start=1 -> fb_x=0, fb_y=0, done=0, timeout_err=0, next READ.
REQ-022 start while busy=1 ignored, no effect on any state or counter.
REQ-023 READ: fb_read=1 every cycle; fb_x/fb_y constant.
REQ-024 READ: fb_data_ready=1 -> capture fb_chunk into 100-bit register, byte index=0, fb_read=0 next cycle, next SEND.
REQ-025 fb_data_ready outside READ ignored.
REQ-026 READ wait counter clears on READ entry; counter reaching TIMEOUT without fb_data_ready -> timeout_err=1, fb_read=0, next IDLE, done stays 0.
REQ-027 SEND: 13 bytes per chunk, LSB first; byte k (0..11) = chunk[8k+7:8k]; byte 12 = {4'b0000, chunk[99:96]}.
REQ-028 SEND: tx_valid=1; byte transfers on cycle with tx_valid=1 and tx_ready=1; index increments on transfer.
REQ-029 tx_data stable and tx_valid held while tx_ready=0; no stall timeout on tx side.
REQ-030 Transfer of byte 12 -> tx_valid=0 next cycle, next ADVANCE.
REQ-031 ADVANCE (one cycle): fb_x+X_STEP < X_LIMIT -> fb_x+=X_STEP; else fb_x=0 and fb_y+=Y_STEP; then READ.
REQ-032 ADVANCE: fb_x+X_STEP >= X_LIMIT and fb_y+Y_STEP >= Y_LIMIT -> fb_x,fb_y unchanged, done=1, next DONE.
REQ-033 Address sums computed 11 bits wide; no wrap of fb_x/fb_y beyond limits.
REQ-034 Chunk raster order: row-major, x fastest; chunk count = ceil(X_LIMIT/X_STEP)*ceil(Y_LIMIT/Y_STEP).
REQ-035 fb_read and tx_valid never high in same cycle.
REQ-036 First fb_read=1 cycle is cycle after start accepted.

Reset
REQ-037 reset=1 -> state IDLE; fb_x=0, fb_y=0, fb_read=0, tx_data=0, tx_valid=0, busy=0, done=0, timeout_err=0, chunk register 0, counters 0.
REQ-038 reset mid-READ or mid-SEND aborts immediately; partial chunk not resumed; next start restarts at (0,0).

Verification
REQ-039 X_LIMIT=20,Y_LIMIT=20, steps 10, framebuffer model answers after 3 cycles, tx_ready=1 -> 4 reads at (0,0),(10,0),(0,10),(10,10), 52 bytes, done=1, busy=0.
REQ-040 fb_chunk=100'h0_1122_3344_5566_7788_99AA_BBCC -> bytes CC,BB,AA,99,88,77,66,55,44,33,22,11,00 in that order.
REQ-041 Chunk with bits[99:96]=4'hF, tx_ready toggling 1/0 every cycle -> byte 12 = 8'h0F, tx_data stable across every stall cycle, no byte lost or duplicated.
REQ-042 TIMEOUT=15, framebuffer never answers -> fb_read high exactly 15 cycles, timeout_err=1, state IDLE, done=0; subsequent start clears timeout_err.
REQ-043 start pulsed during SEND -> ignored, readback completes normally with correct chunk count.
REQ-044 reset asserted during SEND byte 5 -> all outputs at reset values; new start yields first read at (0,0) and first byte = chunk[7:0].

Source files
------------

// File: rtl/fb_readback_sequencer.sv
// fb_readback_sequencer
// Walks the framebuffer in row-major chunk order and streams each 100-bit
// chunk out as 13 bytes, least significant first, to a UART transmitter.
//
// Ports
//   clk, reset       clock (rising edge), asynchronous active-high reset
//   start            one-cycle request to begin a full readback (ignored while busy)
//   fb_x, fb_y       chunk address presented to the framebuffer
//   fb_read          read request, held until fb_data_ready or timeout
//   fb_chunk         chunk data, sampled when fb_data_ready pulses in READ
//   fb_data_ready    one-cycle chunk-valid pulse from the framebuffer
//   tx_data/tx_valid byte stream to the transmitter, held while tx_ready=0
//   tx_ready         transmitter accepts the current byte
//   busy             high while a readback is in progress
//   done             high after a complete readback until the next start
//   timeout_err      sticky, set when the framebuffer failed to answer
module fb_readback_sequencer #(
  parameter int X_STEP  = 10,
  parameter int Y_STEP  = 10,
  parameter int X_LIMIT = 640,
  parameter int Y_LIMIT = 480,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [9:0]   fb_x,
  output logic [9:0]   fb_y,
  output logic         fb_read,
  input  logic [99:0]  fb_chunk,
  input  logic         fb_data_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         done,
  output logic         timeout_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_SEND    = 3'd2;
  localparam logic [2:0] S_ADVANCE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int         CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Counter value on the last permitted READ cycle: READ lasts TIMEOUT cycles.
  localparam logic [CW-1:0] LP_LAST = CW'(TIMEOUT - 1);
  localparam logic [10:0] LP_XS = 11'(X_STEP);
  localparam logic [10:0] LP_YS = 11'(Y_STEP);
  localparam logic [10:0] LP_XL = 11'(X_LIMIT);
  localparam logic [10:0] LP_YL = 11'(Y_LIMIT);

  logic [2:0]    r_state;
  logic [9:0]    r_x, r_y;
  logic [99:0]   r_chunk;
  logic [3:0]    r_idx;
  logic [CW-1:0] r_wait;
  logic          r_done, r_terr;

  logic [10:0]   w_nx, w_ny;
  logic          w_x_ok, w_y_ok;
  logic [103:0]  w_pad;

  // 11-bit sums so a step past the limit is seen instead of wrapping.
  assign w_nx   = {1'b0, r_x} + LP_XS;
  assign w_ny   = {1'b0, r_y} + LP_YS;
  assign w_x_ok = (w_nx < LP_XL);
  assign w_y_ok = (w_ny < LP_YL);

  // Byte 12 carries only the top nibble; zero-pad so all 13 bytes share one mux.
  assign w_pad   = {4'b0000, r_chunk};
  assign tx_data = w_pad[{r_idx, 3'b000} +: 8];

  assign fb_x        = r_x;
  assign fb_y        = r_y;
  assign fb_read     = (r_state == S_READ);
  assign tx_valid    = (r_state == S_SEND);
  assign busy        = (r_state == S_READ) || (r_state == S_SEND) || (r_state == S_ADVANCE);
  assign done        = r_done;
  assign timeout_err = r_terr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_chunk <= '0;
      r_idx   <= '0;
      r_wait  <= '0;
      r_done  <= 1'b0;
      r_terr  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_x     <= '0;
            r_y     <= '0;
            r_wait  <= '0;
            r_done  <= 1'b0;
            r_terr  <= 1'b0;
            r_state <= S_READ;
          end
        end
        S_READ: begin
          // A late answer on the final cycle still wins over the timeout.
          if (fb_data_ready) begin
            r_chunk <= fb_chunk;
            r_idx   <= '0;
            r_state <= S_SEND;
          end else if (r_wait == LP_LAST) begin
            r_terr  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wait  <= r_wait + 1'b1;
          end
        end
        S_SEND: begin
          if (tx_ready) begin
            if (r_idx == 4'd12) r_state <= S_ADVANCE;
            else                r_idx   <= r_idx + 1'b1;
          end
        end
        S_ADVANCE: begin
          r_wait <= '0;
          if (w_x_ok) begin
            r_x     <= w_nx[9:0];
            r_state <= S_READ;
          end else if (w_y_ok) begin
            r_x     <= '0;
            r_y     <= w_ny[9:0];
            r_state <= S_READ;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_readback_sequencer.sv
// Testbench for fb_readback_sequencer: framebuffer responder, transmitter
// ready driver, and a monitor collecting addresses and transferred bytes.
module tb_fb_readback_sequencer;

  localparam int XS = 10, YS = 10, XL = 20, YL = 20, TO = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  fb_x, fb_y;
  logic        fb_read;
  logic [99:0] fb_chunk = '0;
  logic        fb_data_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy, done, timeout_err;

  fb_readback_sequencer #(
    .X_STEP(XS), .Y_STEP(YS), .X_LIMIT(XL), .Y_LIMIT(YL), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .fb_x(fb_x), .fb_y(fb_y), .fb_read(fb_read),
    .fb_chunk(fb_chunk), .fb_data_ready(fb_data_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // responder / ready-driver controls
  bit          fb_en = 1'b1;
  int          fb_lat = 3;
  int          rdy_mode = 0;     // 0 always ready, 1 toggle, 2 random
  logic [99:0] preset_q[$];
  logic [99:0] sent_q[$];

  // monitor observations
  logic [19:0] addr_q[$];
  logic [7:0]  byte_q[$];
  int          rd_cycles = 0;
  int          n_viol = 0;
  int          n_stall = 0;

  function automatic logic [99:0] rnd_chunk();
    return {4'($urandom), $urandom, $urandom, $urandom};
  endfunction

  // Framebuffer answers fb_lat cycles after the request appears; inputs change
  // 1 time unit after the rising edge.
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk); #1;
      fb_data_ready = 1'b0;
      if (reset || !fb_read || !fb_en) cnt = 0;
      else begin
        cnt++;
        if (cnt == fb_lat) begin
          fb_chunk = (preset_q.size() != 0) ? preset_q.pop_front() : rnd_chunk();
          sent_q.push_back(fb_chunk);
          fb_data_ready = 1'b1;
          cnt = 0;
        end
      end
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor on the falling edge, where every signal is settled.
  initial begin
    bit         stall_pend = 1'b0;
    logic [7:0] stall_byte = '0;
    forever begin
      @(negedge clk);
      if (reset) stall_pend = 1'b0;
      else begin
        if (fb_read && tx_valid) n_viol++;
        if (stall_pend && (!tx_valid || tx_data !== stall_byte)) n_viol++;
        stall_pend = tx_valid && !tx_ready;
        stall_byte = tx_data;
        if (stall_pend) n_stall++;
        if (fb_read) rd_cycles++;
        if (fb_read && fb_data_ready) addr_q.push_back({fb_x, fb_y});
        if (tx_valid && tx_ready) byte_q.push_back(tx_data);
      end
    end
  end

  task automatic clear_obs();
    addr_q.delete(); byte_q.delete(); sent_q.delete();
    rd_cycles = 0; n_viol = 0; n_stall = 0;
  endtask

  // Pulse start, note whether fb_read rose the next cycle, wait for !busy.
  task automatic run_frame(input int budget, output bit first_rd, output bit hung);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    first_rd = fb_read;
    hung = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin hung = 1'b0; break; end
      @(posedge clk); #1;
    end
  endtask

  // Counts raster-order address and byte-stream errors against the model.
  function automatic int frame_errors();
    logic [19:0] exp_a[$];
    logic [7:0]  exp_b[$];
    int e = 0;
    for (int y = 0; y < YL; y += YS)
      for (int x = 0; x < XL; x += XS) exp_a.push_back({10'(x), 10'(y)});
    foreach (sent_q[c]) begin
      logic [99:0] ch = sent_q[c];
      for (int k = 0; k < 12; k++) exp_b.push_back(ch[8*k +: 8]);
      exp_b.push_back({4'b0000, ch[99:96]});
    end
    if (addr_q.size() != exp_a.size() || byte_q.size() != exp_b.size()) return 1000;
    foreach (exp_a[i]) if (addr_q[i] !== exp_a[i]) e++;
    foreach (exp_b[i]) if (byte_q[i] !== exp_b[i]) e++;
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1; #12;
    n_tests++;
    if ({fb_x, fb_y, fb_read, tx_data, tx_valid, busy, done, timeout_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got x=%0d y=%0d rd=%b txd=%h txv=%b busy=%b done=%b terr=%b, want all 0",
               fb_x, fb_y, fb_read, tx_data, tx_valid, busy, done, timeout_err);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_full_frame();
    bit fr, hung; int e;
    clear_obs(); fb_en = 1; fb_lat = 3; rdy_mode = 0;
    run_frame(2000, fr, hung);
    e = frame_errors();
    n_tests++;
    if (hung || !fr) begin n_fail++; $display("FAIL full_start: hung=%b first_rd=%b, want 0/1", hung, fr); end
    n_tests++;
    if (addr_q.size() != 4 || byte_q.size() != 52) begin
      n_fail++; $display("FAIL full_counts: reads=%0d bytes=%0d, want 4/52", addr_q.size(), byte_q.size());
    end
    n_tests++;
    if (e != 0) begin n_fail++; $display("FAIL full_data: errors=%0d, want 0", e); end
    n_tests++;
    if (done !== 1'b1 || busy !== 1'b0 || timeout_err !== 1'b0 || n_viol != 0) begin
      n_fail++; $display("FAIL full_end: done=%b busy=%b terr=%b viol=%0d, want 1/0/0/0", done, busy, timeout_err, n_viol);
    end
  endtask

  task automatic test_known_chunk();
    bit fr, hung;
    logic [7:0] want[13] = '{8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h88, 8'h77, 8'h66,
                             8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
    int e = 0;
    clear_obs(); rdy_mode = 0;
    preset_q.push_back(100'h0_1122_3344_5566_7788_99AA_BBCC);
    run_frame(2000, fr, hung);
    for (int k = 0; k < 13; k++) if (byte_q.size() <= k || byte_q[k] !== want[k]) e++;
    n_tests++;
    if (hung || e != 0) begin
      n_fail++; $display("FAIL known_chunk: hung=%b byte errors=%0d first=%h, want 0/0/cc", hung, e,
                         (byte_q.size() != 0) ? byte_q[0] : 8'hxx);
    end
  endtask

  task automatic test_stall();
    bit fr, hung; int e;
    logic [99:0] c = rnd_chunk();
    c[99:96] = 4'hF;
    clear_obs(); rdy_mode = 1;
    preset_q.push_back(c);
    run_frame(4000, fr, hung);
    e = frame_errors();
    n_tests++;
    if (hung || e != 0 || n_viol != 0 || n_stall == 0) begin
      n_fail++; $display("FAIL stall_stream: hung=%b errors=%0d viol=%0d stalls=%0d, want 0/0/0/>0", hung, e, n_viol, n_stall);
    end
    n_tests++;
    if (byte_q.size() < 13 || byte_q[12] !== 8'h0F) begin
      n_fail++; $display("FAIL stall_byte12: got %h, want 0f", (byte_q.size() >= 13) ? byte_q[12] : 8'hxx);
    end
  endtask

  task automatic test_timeout();
    bit fr, hung; int e;
    clear_obs(); fb_en = 0; rdy_mode = 0;
    run_frame(200, fr, hung);
    n_tests++;
    if (hung || rd_cycles != TO) begin
      n_fail++; $display("FAIL timeout_len: hung=%b fb_read cycles=%0d, want 0/%0d", hung, rd_cycles, TO);
    end
    n_tests++;
    if (timeout_err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || fb_read !== 1'b0) begin
      n_fail++; $display("FAIL timeout_flags: terr=%b done=%b busy=%b rd=%b, want 1/0/0/0", timeout_err, done, busy, fb_read);
    end
    clear_obs(); fb_en = 1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n_tests++;
    if (timeout_err !== 1'b0 || fb_read !== 1'b1) begin
      n_fail++; $display("FAIL timeout_clear: terr=%b rd=%b, want 0/1", timeout_err, fb_read);
    end
    hung = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) begin hung = 1'b0; break; end
      @(posedge clk); #1;
    end
    e = frame_errors();
    n_tests++;
    if (hung || e != 0 || done !== 1'b1) begin
      n_fail++; $display("FAIL timeout_recover: hung=%b errors=%0d done=%b, want 0/0/1", hung, e, done);
    end
  endtask

  task automatic test_start_while_busy();
    bit hung = 1'b1; int e;
    clear_obs(); rdy_mode = 2; fb_lat = 2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 200 && !tx_valid; i++) begin @(posedge clk); #1; end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!busy) begin hung = 1'b0; break; end
      @(posedge clk); #1;
    end
    e = frame_errors();
    n_tests++;
    if (hung || e != 0 || addr_q.size() != 4 || done !== 1'b1) begin
      n_fail++; $display("FAIL start_busy: hung=%b errors=%0d reads=%0d done=%b, want 0/0/4/1", hung, e, addr_q.size(), done);
    end
  endtask

  task automatic test_reset_mid_send();
    bit fr, hung;
    clear_obs(); rdy_mode = 0; fb_lat = 3;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    // Byte 5 is being presented once the monitor has logged bytes 0..4
    for (int i = 0; i < 200 && byte_q.size() < 5; i++) begin @(posedge clk); #1; end
    reset = 1'b1; #1;
    n_tests++;
    if (byte_q.size() != 5 ||
        {fb_x, fb_y, fb_read, tx_data, tx_valid, busy, done, timeout_err} !== '0) begin
      n_fail++; $display("FAIL reset_mid_send: bytes=%0d x=%0d y=%0d rd=%b txd=%h txv=%b busy=%b done=%b, want 5 and all 0",
                         byte_q.size(), fb_x, fb_y, fb_read, tx_data, tx_valid, busy, done);
    end
    @(posedge clk); #1 reset = 1'b0;
    clear_obs();
    run_frame(2000, fr, hung);
    n_tests++;
    if (hung || !fr || addr_q.size() == 0 || addr_q[0] !== 20'd0 || byte_q.size() == 0 ||
        sent_q.size() == 0 || byte_q[0] !== sent_q[0][7:0]) begin
      n_fail++; $display("FAIL reset_restart: hung=%b first_rd=%b addr0=%h byte0=%h, want 0/1/00000/%h",
                         hung, fr, (addr_q.size() != 0) ? addr_q[0] : 20'hx,
                         (byte_q.size() != 0) ? byte_q[0] : 8'hxx, (sent_q.size() != 0) ? sent_q[0][7:0] : 8'hxx);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      bit fr, hung; int e;
      clear_obs(); rdy_mode = 2; fb_lat = $urandom_range(1, 8);
      run_frame(4000, fr, hung);
      e = frame_errors();
      n_tests++;
      if (hung || !fr || e != 0 || n_viol != 0 || done !== 1'b1) begin
        n_fail++; $display("FAIL random_%0d: lat=%0d hung=%b first_rd=%b errors=%0d viol=%0d done=%b, want 0/1/0/0/1",
                           r, fb_lat, hung, fr, e, n_viol, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_known_chunk();
    test_stall();
    test_timeout();
    test_start_while_busy();
    test_reset_mid_send();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
